// File: rtl/packet_replicator_pkg.sv
// Shared types and default sizes for the packet replicator and its statistics bank.
package packet_replicator_pkg;

  localparam int DEF_DATA_WIDTH  = 256;
  localparam int DEF_TUSER_WIDTH = 128;
  localparam int DEF_CNT_WIDTH   = 32;
  localparam int MAX_OUTPUTS     = 16;

  typedef enum logic [1:0] {
    ST_SOP  = 2'd0,
    ST_MID  = 2'd1,
    ST_DROP = 2'd2
  } rep_state_e;

endpackage

// File: rtl/packet_replicator_stats.sv
// Per-output packet-delivered and packet-dropped counters; wrap modulo 2^CNT_WIDTH.
module replicator_stats
  import packet_replicator_pkg::*;
#(
  parameter int NUM_OUTPUTS = 4,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_OUTPUTS-1:0]           pkt_inc_i,
  input  logic [NUM_OUTPUTS-1:0]           drop_inc_i,
  output logic [NUM_OUTPUTS*CNT_WIDTH-1:0] pkt_count_o,
  output logic [NUM_OUTPUTS*CNT_WIDTH-1:0] drop_count_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_cnt
    logic [CNT_WIDTH-1:0] pkt_q;
    logic [CNT_WIDTH-1:0] drop_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        pkt_q  <= '0;
        drop_q <= '0;
      end else begin
        if (pkt_inc_i[g])  pkt_q  <= pkt_q + CNT_ONE;
        if (drop_inc_i[g]) drop_q <= drop_q + CNT_ONE;
      end
    end

    assign pkt_count_o[g*CNT_WIDTH +: CNT_WIDTH]  = pkt_q;
    assign drop_count_o[g*CNT_WIDTH +: CNT_WIDTH] = drop_q;
  end

endmodule

// File: rtl/packet_replicator.sv
// Forks one AXI4-Stream ingress into NUM_OUTPUTS egress streams with per-packet output selection.
// Optional statistics counters are enabled by defining PACKET_REPLICATOR_STATS_EN.
module packet_replicator
  import packet_replicator_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int C_AXIS_TUSER_WIDTH = DEF_TUSER_WIDTH,
  parameter int NUM_OUTPUTS        = 4,
  parameter int CNT_WIDTH          = DEF_CNT_WIDTH
) (
  input  logic                             axi_aclk,
  input  logic                             axi_aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic                             m_axis_tlast,
  output logic [NUM_OUTPUTS-1:0]           m_axis_tvalid,
  input  logic [NUM_OUTPUTS-1:0]           m_axis_tready,
  input  logic [NUM_OUTPUTS-1:0]           out_en,
  input  logic [NUM_OUTPUTS-1:0]           lossy_mask,
  output logic [NUM_OUTPUTS*CNT_WIDTH-1:0] pkt_count,
  output logic [NUM_OUTPUTS*CNT_WIDTH-1:0] drop_count
);

  if (NUM_OUTPUTS < 1 || NUM_OUTPUTS > MAX_OUTPUTS) begin : g_bad_cfg
    $error("packet_replicator: NUM_OUTPUTS out of range");
  end

  rep_state_e                      state_q, state_d;
  logic                            hold_valid_q, hold_valid_d;
  logic [NUM_OUTPUTS-1:0]          pend_q, pend_d;
  logic [NUM_OUTPUTS-1:0]          act_mask_q, act_mask_d;
  logic [C_AXIS_DATA_WIDTH-1:0]    data_q;
  logic [C_AXIS_DATA_WIDTH/8-1:0]  strb_q;
  logic [C_AXIS_TUSER_WIDTH-1:0]   user_q;
  logic                            last_q;

  logic [NUM_OUTPUTS-1:0] pend_left;
  logic [NUM_OUTPUTS-1:0] sop_mask;
  logic [NUM_OUTPUTS-1:0] load_mask;
  logic                   ready_int;
  logic                   in_acc;
  logic                   load;

  // Outputs still owed the held beat after this cycle's handshakes.
  assign pend_left = hold_valid_q ? (pend_q & ~m_axis_tready) : '0;
  assign sop_mask  = out_en & ~(lossy_mask & ~m_axis_tready);
  assign ready_int = (state_q == ST_DROP) | ~hold_valid_q | (pend_left == '0);
  assign in_acc    = s_axis_tvalid & ready_int;

  always_comb begin
    state_d    = state_q;
    act_mask_d = act_mask_q;
    load       = 1'b0;
    load_mask  = act_mask_q;
    unique case (state_q)
      ST_SOP: begin
        if (in_acc) begin
          if (sop_mask != '0) begin
            load       = 1'b1;
            load_mask  = sop_mask;
            act_mask_d = sop_mask;
            if (!s_axis_tlast) state_d = ST_MID;
          end else if (!s_axis_tlast) begin
            state_d = ST_DROP;
          end
        end
      end
      ST_MID: begin
        if (in_acc) begin
          load = 1'b1;
          if (s_axis_tlast) state_d = ST_SOP;
        end
      end
      ST_DROP: begin
        if (in_acc && s_axis_tlast) state_d = ST_SOP;
      end
      default: state_d = ST_SOP;
    endcase

    // A new beat may replace the held one in the cycle its last pend bit clears.
    if (load) begin
      pend_d       = load_mask;
      hold_valid_d = 1'b1;
    end else begin
      pend_d       = pend_left;
      hold_valid_d = |pend_left;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q      <= ST_SOP;
      hold_valid_q <= 1'b0;
      pend_q       <= '0;
      act_mask_q   <= '0;
      data_q       <= '0;
      strb_q       <= '0;
      user_q       <= '0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      pend_q       <= pend_d;
      act_mask_q   <= act_mask_d;
      if (load) begin
        data_q <= s_axis_tdata;
        strb_q <= s_axis_tstrb;
        user_q <= s_axis_tuser;
        last_q <= s_axis_tlast;
      end
    end
  end

  assign s_axis_tready = ready_int;
  assign m_axis_tdata  = data_q;
  assign m_axis_tstrb  = strb_q;
  assign m_axis_tuser  = user_q;
  assign m_axis_tlast  = last_q;
  assign m_axis_tvalid = pend_q & {NUM_OUTPUTS{hold_valid_q}};

`ifdef PACKET_REPLICATOR_STATS_EN
  logic [NUM_OUTPUTS-1:0] pkt_inc;
  logic [NUM_OUTPUTS-1:0] drop_inc;

  assign pkt_inc  = m_axis_tvalid & m_axis_tready & {NUM_OUTPUTS{last_q}};
  assign drop_inc = (state_q == ST_SOP && in_acc) ? (out_en & lossy_mask & ~m_axis_tready) : '0;

  replicator_stats #(
    .NUM_OUTPUTS (NUM_OUTPUTS),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_stats (
    .clk_i        (axi_aclk),
    .rst_ni       (axi_aresetn),
    .pkt_inc_i    (pkt_inc),
    .drop_inc_i   (drop_inc),
    .pkt_count_o  (pkt_count),
    .drop_count_o (drop_count)
  );
`else
  assign pkt_count  = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_packet_replicator.sv
// Scoreboard bench for packet_replicator: expected beats are queued per output at ingress accept.
module tb_packet_replicator;

  localparam int DW = 32;
  localparam int UW = 16;
  localparam int SW = DW / 8;
  localparam int N  = 4;
  localparam int CW = 32;
  localparam int BW = 1 + UW + SW + DW;

  typedef logic [BW-1:0] beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_tdata;
  logic [SW-1:0] s_tstrb;
  logic [UW-1:0] s_tuser;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [DW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic [UW-1:0] m_tuser;
  logic          m_tlast;
  logic [N-1:0]  m_tvalid;
  logic [N-1:0]  m_tready;
  logic [N-1:0]  out_en;
  logic [N-1:0]  lossy;
  logic [N*CW-1:0] pkt_count;
  logic [N*CW-1:0] drop_count;

  beat_t exp_q [N][$];
  int    checks   = 0;
  int    failures = 0;
  int    stall_cnt;
  int    exp_pkt  [N];
  int    exp_drop [N];

  always #5 clk = ~clk;

  packet_replicator #(
    .C_AXIS_DATA_WIDTH  (DW),
    .C_AXIS_TUSER_WIDTH (UW),
    .NUM_OUTPUTS        (N),
    .CNT_WIDTH          (CW)
  ) dut (
    .axi_aclk      (clk),
    .axi_aresetn   (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .out_en        (out_en),
    .lossy_mask    (lossy),
    .pkt_count     (pkt_count),
    .drop_count    (drop_count)
  );

  // Egress monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    beat_t got, want;
    if (rst_n) begin
      if (s_tvalid && !s_tready) stall_cnt++;
      got = {m_tlast, m_tuser, m_tstrb, m_tdata};
      for (int i = 0; i < N; i++) begin
        if (m_tvalid[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_valid out=%0d got valid=1 want 0", i);
          end else if (m_tready[i]) begin
            want = exp_q[i].pop_front();
            checks++;
            if (got !== want) begin
              failures++;
              $display("FAIL beat out=%0d got %h want %h", i, got, want);
            end
          end
        end
      end
    end
  end

  task automatic send_packet(input int nbeats, input logic [N-1:0] expmask);
    int waited;
    bit accepted;
    for (int b = 0; b < nbeats; b++) begin
      s_tdata  = DW'($urandom);
      s_tstrb  = SW'($urandom);
      s_tuser  = UW'($urandom);
      s_tlast  = (b == nbeats - 1);
      s_tvalid = 1'b1;
      accepted = 1'b0;
      waited   = 0;
      while (!accepted) begin
        @(negedge clk);
        if (s_tready) begin
          accepted = 1'b1;
          for (int i = 0; i < N; i++)
            if (expmask[i]) exp_q[i].push_back({s_tlast, s_tuser, s_tstrb, s_tdata});
        end
        @(posedge clk);
        #1;
        waited++;
        if (!accepted && waited > 200) begin
          checks++;
          failures++;
          $display("FAIL ingress_timeout beat=%0d got tready=0 want 1", b);
          s_tvalid = 1'b0;
          return;
        end
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    for (int i = 0; i < N; i++) if (expmask[i]) exp_pkt[i]++;
  endtask

  task automatic drain(input string name);
    int left;
    for (int c = 0; c < 100; c++) begin
      left = 0;
      for (int i = 0; i < N; i++) left += exp_q[i].size();
      if (left == 0) break;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        failures++;
        $display("FAIL %s_drain out=%0d got %0d beats outstanding want 0", name, i, exp_q[i].size());
      end
    end
  endtask

  task automatic check_counters(input string name);
    logic [CW-1:0] want_p, want_d;
    for (int i = 0; i < N; i++) begin
`ifdef PACKET_REPLICATOR_STATS_EN
      want_p = CW'(exp_pkt[i]);
      want_d = CW'(exp_drop[i]);
`else
      want_p = '0;
      want_d = '0;
`endif
      checks += 2;
      if (pkt_count[i*CW +: CW] !== want_p) begin
        failures++;
        $display("FAIL %s_pkt_count out=%0d got %0d want %0d", name, i, pkt_count[i*CW +: CW], want_p);
      end
      if (drop_count[i*CW +: CW] !== want_d) begin
        failures++;
        $display("FAIL %s_drop_count out=%0d got %0d want %0d", name, i, drop_count[i*CW +: CW], want_d);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (m_tvalid !== '0) begin failures++; $display("FAIL reset_tvalid got %b want 0000", m_tvalid); end
    if (m_tdata !== '0) begin failures++; $display("FAIL reset_tdata got %h want 0", m_tdata); end
    if (m_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got %b want 0", m_tlast); end
    if (s_tready !== 1'b1) begin failures++; $display("FAIL reset_tready got %b want 1", s_tready); end
    check_counters("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_broadcast();
    out_en    = 4'b1111;
    lossy     = 4'b0000;
    m_tready  = 4'b1111;
    stall_cnt = 0;
    fork
      send_packet(3, 4'b1111);
      begin
        @(negedge clk);
        checks++;
        if (m_tvalid !== 4'b0000) begin failures++; $display("FAIL bcast_latency0 got %b want 0000", m_tvalid); end
        @(negedge clk);
        checks++;
        if (m_tvalid !== 4'b1111) begin failures++; $display("FAIL bcast_latency1 got %b want 1111", m_tvalid); end
      end
    join
    drain("bcast");
    checks++;
    if (stall_cnt != 0) begin failures++; $display("FAIL bcast_stalls got %0d want 0", stall_cnt); end
    check_counters("bcast");
  endtask

  task automatic test_blocking_stall();
    out_en    = 4'b0101;
    stall_cnt = 0;
    fork
      send_packet(4, 4'b0101);
      begin
        repeat (2) @(posedge clk);
        #1;
        m_tready[2] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        m_tready[2] = 1'b1;
      end
    join
    drain("stall");
    checks++;
    if (stall_cnt != 5) begin failures++; $display("FAIL stall_cycles got %0d want 5", stall_cnt); end
    check_counters("stall");
  endtask

  task automatic test_lossy();
    out_en   = 4'b1111;
    lossy    = 4'b0010;
    m_tready = 4'b1101;
    send_packet(4, 4'b1101);
    exp_drop[1]++;
    m_tready = 4'b1111;
    lossy    = 4'b0000;
    drain("lossy");
    check_counters("lossy");
  endtask

  task automatic test_disabled();
    time t0;
    out_en    = 4'b0000;
    stall_cnt = 0;
    t0        = $time;
    send_packet(2, 4'b0000);
    checks += 2;
    if ($time - t0 != 20) begin failures++; $display("FAIL off_rate got %0t want 20", $time - t0); end
    if (stall_cnt != 0) begin failures++; $display("FAIL off_stalls got %0d want 0", stall_cnt); end
    repeat (3) @(posedge clk);
    #1;
    drain("off");
    check_counters("off");
  endtask

  task automatic test_mask_change();
    out_en = 4'b0001;
    fork
      send_packet(3, 4'b0001);
      begin
        @(posedge clk);
        #1;
        out_en = 4'b1111;
        lossy  = 4'b1111;
      end
    join
    send_packet(2, 4'b1111);
    lossy = 4'b0000;
    drain("maskchg");
    check_counters("maskchg");
  endtask

  task automatic test_reset_midpkt();
    out_en   = 4'b1111;
    m_tready = 4'b1111;
    for (int b = 0; b < 3; b++) begin
      s_tdata  = DW'($urandom);
      s_tstrb  = SW'($urandom);
      s_tuser  = UW'($urandom);
      s_tlast  = 1'b0;
      s_tvalid = 1'b1;
      if (b == 2) break;
      @(negedge clk);
      checks++;
      if (s_tready !== 1'b1) begin failures++; $display("FAIL rstmid_tready beat=%0d got 0 want 1", b); end
      for (int i = 0; i < N; i++) exp_q[i].push_back({s_tlast, s_tuser, s_tstrb, s_tdata});
      @(posedge clk);
      #1;
    end
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_q[i].delete();
      exp_pkt[i]  = 0;
      exp_drop[i] = 0;
    end
    #1;
    checks++;
    if (m_tvalid !== 4'b0000) begin failures++; $display("FAIL rstmid_tvalid got %b want 0000", m_tvalid); end
    check_counters("rstmid_in_reset");
    s_tvalid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (s_tready !== 1'b1) begin failures++; $display("FAIL rstmid_ready_after got %b want 1", s_tready); end
    send_packet(1, 4'b1111);
    drain("rstmid");
    check_counters("rstmid");
  endtask

  initial begin
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tuser  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 4'b1111;
    out_en   = 4'b0000;
    lossy    = 4'b0000;
    for (int i = 0; i < N; i++) begin
      exp_pkt[i]  = 0;
      exp_drop[i] = 0;
    end
    stall_cnt = 0;
    test_reset();
    test_broadcast();
    test_blocking_stall();
    test_lossy();
    test_disabled();
    test_mask_change();
    test_reset_midpkt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
